// File: rtl/icache_refill_engine.sv
// Icache block refill: fetch N words from the network, accept them in any order, write them in offset order.
// Optional ICACHE_REFILL_PERF_CNT_EN adds refill/stall counters. Latency >= 2N+2 cycles miss-to-done; no backpressure on writes.
module icache_refill_engine #(
  parameter int icache_tag_width_p           = 12,
  parameter int icache_entries_p             = 1024,
  parameter int icache_block_size_in_words_p = 4,
  localparam int pc_width_lp     = icache_tag_width_p + $clog2(icache_entries_p),
  localparam int offset_width_lp = $clog2(icache_block_size_in_words_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       miss_v_i,
  input  logic [pc_width_lp-1:0]     miss_pc_i,
  output logic                       busy_o,
  output logic                       req_v_o,
  output logic [pc_width_lp-1:0]     req_pc_o,
  input  logic                       req_ready_i,
  input  logic                       resp_v_i,
  input  logic [offset_width_lp-1:0] resp_offset_i,
  input  logic [31:0]                resp_data_i,
  output logic                       icache_v_o,
  output logic                       icache_w_o,
  output logic [pc_width_lp-1:0]     icache_pc_o,
  output logic [31:0]                icache_instr_o,
  output logic                       done_o
`ifdef ICACHE_REFILL_PERF_CNT_EN
  ,
  output logic [31:0]                refill_cnt_o,
  output logic [31:0]                stall_cnt_o
`endif
);

  localparam int n_lp = icache_block_size_in_words_p;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [offset_width_lp-1:0] last_lp   = offset_width_lp'(n_lp - 1);
  localparam logic [pc_width_lp-1:0]     off_msk_lp = pc_width_lp'(n_lp - 1);

  logic [2:0]                 state_r;
  logic [pc_width_lp-1:0]     base_r;
  logic [offset_width_lp-1:0] req_cnt_r;
  logic [offset_width_lp-1:0] wr_cnt_r;
  logic [n_lp-1:0]            vld_r;
  logic [n_lp-1:0]            vld_n;
  logic [n_lp-1:0]            resp_onehot;
  logic [31:0]                data_r [n_lp];
  logic                       resp_acc;
  logic                       in_write;

  assign resp_acc    = resp_v_i && (state_r == REQ || state_r == WAIT);
  assign resp_onehot = resp_acc ? ({{(n_lp-1){1'b0}}, 1'b1} << resp_offset_i) : '0;
  assign vld_n       = vld_r | resp_onehot;
  assign in_write    = (state_r == WRITE);

  assign busy_o         = (state_r != IDLE);
  assign req_v_o        = (state_r == REQ);
  // Base has its offset bits zeroed, so OR-ing the count in never carries out of the block.
  assign req_pc_o       = req_v_o ? (base_r | pc_width_lp'(req_cnt_r)) : '0;
  assign icache_v_o     = in_write;
  assign icache_w_o     = in_write;
  assign icache_pc_o    = in_write ? (base_r | pc_width_lp'(wr_cnt_r)) : '0;
  assign icache_instr_o = in_write ? data_r[wr_cnt_r] : '0;
  assign done_o         = (state_r == DONE);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= IDLE;
      base_r    <= '0;
      req_cnt_r <= '0;
      wr_cnt_r  <= '0;
    end else begin
      case (state_r)
        IDLE: if (miss_v_i) begin
          base_r    <= miss_pc_i & ~off_msk_lp;
          req_cnt_r <= '0;
          state_r   <= REQ;
        end
        REQ: if (req_ready_i) begin
          req_cnt_r <= req_cnt_r + 1'b1;
          if (req_cnt_r == last_lp) state_r <= WAIT;
        end
        WAIT: if (&vld_n) begin
          wr_cnt_r <= '0;
          state_r  <= WRITE;
        end
        WRITE: begin
          wr_cnt_r <= wr_cnt_r + 1'b1;
          if (wr_cnt_r == last_lp) state_r <= DONE;
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)            vld_r <= '0;
    else if (state_r == DONE)  vld_r <= '0;
    else if (resp_acc)         vld_r <= vld_n;
  end

  always_ff @(posedge clk_i) begin
    if (resp_acc) data_r[resp_offset_i] <= resp_data_i;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i && resp_v_i) begin
      if (!resp_acc) $error("icache_refill_engine: response dropped outside REQ/WAIT");
      else if (vld_r[resp_offset_i]) $error("icache_refill_engine: duplicate response offset %0d", resp_offset_i);
    end
  end
`endif

`ifdef ICACHE_REFILL_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      refill_cnt_o <= '0;
      stall_cnt_o  <= '0;
    end else begin
      if (done_o) refill_cnt_o <= refill_cnt_o + 32'd1;
      if (busy_o) stall_cnt_o  <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule
